// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces the side-road sensor and walk button.
// WALK_LATCH_EN: walk is a level held until walk_ack rises; otherwise walk is a 1-clk press pulse.
module input_conditioner #(
    parameter int DEBOUNCE    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       raw_sensor,
    input  logic       raw_walk,
    input  logic       walk_ack,
    output logic       sensor,
    output logic       walk,
    output logic [7:0] sensor_events
);
    logic [SYNC_STAGES-1:0] sync_s, sync_w;
    logic [1:0] synced, lvl, flip;
    logic [3:0] cnt [2];
    logic       walk_d, press;

    assign synced = {sync_w[SYNC_STAGES-1], sync_s[SYNC_STAGES-1]};
    assign sensor = lvl[0];
    assign press  = lvl[1] & ~walk_d;

    // flip marks the tick on which a differing sample completes the DEBOUNCE run
    always_comb begin
        flip = '0;
        for (int i = 0; i < 2; i++)
            flip[i] = tick && (synced[i] != lvl[i]) && (cnt[i] == 4'(DEBOUNCE - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_s        <= '0;
            sync_w        <= '0;
            lvl           <= '0;
            cnt           <= '{default: '0};
            walk_d        <= 1'b0;
            sensor_events <= '0;
        end else begin
            sync_s <= {sync_s[SYNC_STAGES-2:0], raw_sensor};
            sync_w <= {sync_w[SYNC_STAGES-2:0], raw_walk};
            for (int i = 0; i < 2; i++)
                if (tick)
                    cnt[i] <= (synced[i] == lvl[i] || flip[i]) ? 4'd0 : cnt[i] + 4'd1;
            lvl    <= lvl ^ flip;
            walk_d <= lvl[1];
            if (flip[0] && !lvl[0] && sensor_events != 8'hFF)
                sensor_events <= sensor_events + 8'd1;
        end
    end

`ifdef WALK_LATCH_EN
    logic [1:0] ack_q;
    logic       ack_rise;

    assign ack_rise = ack_q[0] & ~ack_q[1];

    // a press in the same cycle as an ack rise keeps the request set
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q <= '0;
            walk  <= 1'b0;
        end else begin
            ack_q <= {ack_q[0], walk_ack};
            walk  <= press | (walk & ~ack_rise);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset)
            walk <= 1'b0;
        else
            walk <= press;
    end
`endif
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed checks of debounce timing, event saturation and walk behaviour.
module tb_input_conditioner;
    logic       clk = 0, reset = 1, tick = 1;
    logic       raw_sensor = 0, raw_walk = 0, walk_ack = 0;
    logic       sensor, walk;
    logic [7:0] sensor_events;
    int         checks = 0, fails = 0;

    input_conditioner #(.DEBOUNCE(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .raw_sensor(raw_sensor), .raw_walk(raw_walk), .walk_ack(walk_ack),
        .sensor(sensor), .walk(walk), .sensor_events(sensor_events)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        step(2);
        check("rst_sensor", {7'd0, sensor}, 8'd0);
        check("rst_walk", {7'd0, walk}, 8'd0);
        check("rst_events", sensor_events, 8'd0);
        reset = 0;
        step(2);

        // stable rise: sensor after exactly 6 edges
        raw_sensor = 1;
        step(5);
        check("rise_edge5", {7'd0, sensor}, 8'd0);
        step(1);
        check("rise_edge6", {7'd0, sensor}, 8'd1);
        check("rise_events", sensor_events, 8'd1);
        step(14);
        raw_sensor = 0;
        step(10);
        check("fall_sensor", {7'd0, sensor}, 8'd0);
        check("fall_events", sensor_events, 8'd1);

        // 3-clk glitch is rejected
        raw_sensor = 1;
        step(3);
        raw_sensor = 0;
        step(10);
        check("glitch_sensor", {7'd0, sensor}, 8'd0);
        check("glitch_events", sensor_events, 8'd1);

        // tick low holds the counter; sync keeps shifting
        tick = 0;
        raw_sensor = 1;
        step(20);
        check("tick0_hold", {7'd0, sensor}, 8'd0);
        tick = 1;
        step(3);
        check("tick1_edge3", {7'd0, sensor}, 8'd0);
        step(1);
        check("tick1_edge4", {7'd0, sensor}, 8'd1);
        check("tick1_events", sensor_events, 8'd2);
        raw_sensor = 0;
        step(10);

`ifdef WALK_LATCH_EN
        raw_walk = 1;
        step(6);
        check("latch_edge6", {7'd0, walk}, 8'd0);
        step(1);
        check("latch_edge7", {7'd0, walk}, 8'd1);
        step(3);
        raw_walk = 0;
        step(10);
        check("latch_hold", {7'd0, walk}, 8'd1);
        walk_ack = 1;
        step(1);
        check("ack_edge1", {7'd0, walk}, 8'd1);
        step(1);
        check("ack_edge2", {7'd0, walk}, 8'd0);
        walk_ack = 0;
        step(10);
        // press detection lands in the same cycle as the ack rise
        raw_walk = 1;
        step(5);
        walk_ack = 1;
        step(1);
        check("tie_edge6", {7'd0, walk}, 8'd0);
        step(1);
        check("tie_set_wins", {7'd0, walk}, 8'd1);
        step(5);
        check("tie_stays", {7'd0, walk}, 8'd1);
        raw_walk = 0;
        walk_ack = 0;
        step(10);
`else
        for (int p = 0; p < 2; p++) begin
            raw_walk = 1;
            for (int i = 0; i < 20; i++) begin
                walk_ack = i[0];
                step(1);
                check($sformatf("pulse%0d_c%0d", p, i), {7'd0, walk}, (i == 6) ? 8'd1 : 8'd0);
            end
            raw_walk = 0;
            step(10);
            check($sformatf("pulse%0d_after", p), {7'd0, walk}, 8'd0);
        end
        walk_ack = 0;
`endif

        // 300 debounced pulses saturate the event counter
        for (int n = 0; n < 300; n++) begin
            raw_sensor = 1;
            step(8);
            raw_sensor = 0;
            step(8);
            if (n == 100) check("events_101", sensor_events, 8'd103);
        end
        check("events_sat", sensor_events, 8'd255);

        // reset mid-debounce, raw held high through release
        raw_sensor = 1;
        raw_walk = 1;
        step(4);
        reset = 1;
        step(1);
        check("midrst_sensor", {7'd0, sensor}, 8'd0);
        check("midrst_walk", {7'd0, walk}, 8'd0);
        check("midrst_events", sensor_events, 8'd0);
        reset = 0;
        step(5);
        check("post_edge5", {7'd0, sensor}, 8'd0);
        step(1);
        check("post_edge6", {7'd0, sensor}, 8'd1);
        check("post_events", sensor_events, 8'd1);
        step(1);
        check("post_press", {7'd0, walk}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE, default 4, number of consecutive qualifying tick samples needed to change a debounced level; legal range 1..15.
REQ-002 Parameter SYNC_STAGES, default 2, depth of the flop chain on each raw input; legal range 2..3.
REQ-003 clk  input  1  Block clock.
REQ-004 reset  input  1  Reset: synchronous, active-high.
REQ-005 tick  input  1  Sample enable; debounce counters advance only in cycles where tick=1.
REQ-006 raw_sensor  input  1  Asynchronous vehicle-presence contact on the side road.
REQ-007 raw_walk  input  1  Asynchronous pedestrian push button.
REQ-008 walk_ack  input  1  Walk-phase indication from the intersection controller (its walk_light).
REQ-009 sensor  output  1  Debounced vehicle-presence level.
REQ-010 walk  output  1  Pedestrian request to the intersection controller.
REQ-011 sensor_events  output  8  Saturating count of debounced sensor rising edges.

Function
REQ-012 Each raw input SHALL pass through a SYNC_STAGES-deep flop chain; no logic on raw inputs before the first flop.
REQ-013 Each channel SHALL keep a 4-bit counter and a debounced level; on tick, a synced value different from the debounced level increments the counter, and an equal value clears it.
REQ-014 The debounced level SHALL toggle, and its counter clear, on the tick edge where the counter would reach DEBOUNCE.
REQ-015 With tick held high and DEBOUNCE=4, sensor SHALL follow a stable raw_sensor change exactly SYNC_STAGES+DEBOUNCE clk edges later.
REQ-016 A glitch shorter than DEBOUNCE ticks SHALL produce no change on sensor or walk.
REQ-017 With tick=0, counters and debounced levels SHALL hold; the sync chains SHALL keep shifting.
REQ-018 sensor SHALL equal the debounced sensor level, registered.
REQ-019 A press SHALL be a rising edge of the debounced walk level; it is detected one clk after the debounced level rises.
REQ-020 A walk_ack rise SHALL be detected from a registered copy of walk_ack (1 clk).
REQ-021 sensor_events SHALL increment by 1 on each debounced sensor rising edge and saturate at 255; it does not wrap.
REQ-022 Holding the button SHALL produce only one press; a new press requires debounced release, then a debounced re-press.

Reset
REQ-023 On reset, the following SHALL clear to 0 on the next clk edge, regardless of tick: sync flops, counters, debounced levels, the walk_ack register, sensor, walk and sensor_events.
REQ-024 Reset asserted mid-debounce SHALL discard partial counts; after reset, a full DEBOUNCE run is needed again.
REQ-025 A raw input held high through reset release SHALL be reported after SYNC_STAGES+DEBOUNCE edges as a fresh rising edge (press or sensor event).

Configuration
REQ-026 Macro WALK_LATCH_EN SHALL select the walk output behaviour.
REQ-027 With WALK_LATCH_EN defined:
- walk is a level, set by a press and cleared on a detected walk_ack rise.
- If a press and an ack rise occur in the same cycle, the set wins and walk stays 1.
- Further presses while walk=1 have no effect.
REQ-028 With WALK_LATCH_EN undefined:
- walk is a single-clk pulse per press.
- walk_ack is ignored, and its register may be removed.

Verification
REQ-029 tick=1, DEBOUNCE=4; raw_sensor 0->1 held 20 clks -> sensor=1 exactly 6 edges after the change; sensor_events=1.
REQ-030 tick=1, DEBOUNCE=4; raw_sensor high for 3 clks, then low -> sensor stays 0; sensor_events stays 0.
REQ-031 WALK_LATCH_EN defined; raw_walk pulsed high for 10 clks -> walk=1 on edge 7 and stays 1; walk_ack 0->1 -> walk=0 two edges later.
REQ-032 WALK_LATCH_EN defined; press detection forced into the same cycle as a walk_ack rise -> walk remains 1.
REQ-033 WALK_LATCH_EN undefined; two separated debounced presses -> exactly two 1-clk walk pulses; walk_ack toggling has no effect.
REQ-034 Drive 300 debounced sensor pulses, then assert reset for 1 clk mid-debounce -> sensor_events=255 before reset; after reset, all outputs are 0 on the next edge.
